// File: rtl/sysid_pkg.sv
// Shared word map, capability-word layout and read-pipeline stage type for the
// sysid register block.
package sysid_pkg;

    localparam int ADDR_ID        = 0;
    localparam int ADDR_TIMESTAMP = 1;
    localparam int ADDR_UPTIME_LO = 2;
    localparam int ADDR_UPTIME_HI = 3;
    localparam int ADDR_SCRATCH   = 4;
    localparam int ADDR_CAPS      = 5;
    localparam int ADDR_USER0     = 6;

    localparam int CAPS_LATENCY_LSB  = 0;
    localparam int CAPS_NUM_USER_LSB = 8;
    localparam int CAPS_VERSION_LSB  = 16;

    localparam logic [7:0] VERSION_DEFAULT = 8'h02;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_stage_t;

    function automatic logic [31:0] caps_word(input logic [7:0] version,
                                              input int         num_user,
                                              input int         read_latency);
        logic [31:0] w;
        w = '0;
        w[CAPS_VERSION_LSB  +: 8] = version;
        w[CAPS_NUM_USER_LSB +: 8] = 8'(num_user);
        w[CAPS_LATENCY_LSB  +: 8] = 8'(read_latency);
        return w;
    endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle for the sysid register block (no waitrequest).
interface sysid_regs_if #(
    parameter int ADDR_WIDTH = 5
) ();

    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/sysid_uptime.sv
// Free-running 64-bit uptime counter with synchronous clear and a shadow of the
// high word captured whenever the low word is read.
module sysid_uptime (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] count;
    logic [31:0] shadow;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            shadow <= '0;
        end else begin
            if (clear) begin
                count <= '0;
            end else begin
                count <= count + 64'd1;
            end
            // Captures the same pre-increment value whose low half is being returned.
            if (snap) begin
                shadow <= count[63:32];
            end
        end
    end

    assign lo        = count[31:0];
    assign hi_shadow = shadow;

endmodule

// File: rtl/sysid_regs.sv
// System-identification register block: build ID/timestamp, uptime with coherent
// 64-bit snapshot, scratch, capability word and user status words.
module sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd1299134001,
    parameter int          NUM_USER     = 4,
    parameter int          ADDR_WIDTH   = 5,
    parameter int          READ_LATENCY = 1,
    parameter logic [7:0]  VERSION      = VERSION_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    sysid_regs_if.slave            bus,
    input  logic [32*NUM_USER-1:0] user_status
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t       A_ID      = addr_t'(ADDR_ID);
    localparam addr_t       A_TSTAMP  = addr_t'(ADDR_TIMESTAMP);
    localparam addr_t       A_UP_LO   = addr_t'(ADDR_UPTIME_LO);
    localparam addr_t       A_UP_HI   = addr_t'(ADDR_UPTIME_HI);
    localparam addr_t       A_SCRATCH = addr_t'(ADDR_SCRATCH);
    localparam addr_t       A_CAPS    = addr_t'(ADDR_CAPS);
    localparam logic [31:0] CAPS      = caps_word(VERSION, NUM_USER, READ_LATENCY);

    addr_t       addr;
    logic        rd_acc;
    logic        wr_acc;
    logic        up_clear;
    logic        up_snap;
    logic [31:0] up_lo;
    logic [31:0] up_hi;
    logic [31:0] scratch;
    logic [31:0] rd_mux;
    rd_stage_t   pipe [READ_LATENCY];

    // A write in the same cycle as a read wins; the read is dropped entirely.
    assign addr     = bus.address;
    assign wr_acc   = bus.write;
    assign rd_acc   = bus.read & ~bus.write;
    assign up_clear = wr_acc && (addr == A_UP_LO);
    assign up_snap  = rd_acc && (addr == A_UP_LO);

    sysid_uptime u_uptime (
        .clock     (clock),
        .reset     (reset),
        .clear     (up_clear),
        .snap      (up_snap),
        .lo        (up_lo),
        .hi_shadow (up_hi)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= '0;
        end else if (wr_acc && (addr == A_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (addr)
            A_ID:      rd_mux = ID_VALUE;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_UP_LO:   rd_mux = up_lo;
            A_UP_HI:   rd_mux = up_hi;
            A_SCRATCH: rd_mux = scratch;
            A_CAPS:    rd_mux = CAPS;
            default: begin
                for (int k = 0; k < NUM_USER; k++) begin
                    if (addr == addr_t'(ADDR_USER0 + k)) begin
                        rd_mux = user_status[32*k +: 32];
                    end
                end
            end
        endcase
    end

    // NOTE: the read pipeline is a few flops, not a RAM, so it is reset outright; that is what discards reads in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= rd_acc;
            if (rd_acc) begin
                pipe[0].data <= rd_mux;
            end
            // Data only moves with a valid, so readdata holds between responses.
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i].valid <= pipe[i-1].valid;
                if (pipe[i-1].valid) begin
                    pipe[i].data <= pipe[i-1].data;
                end
            end
        end
    end

    assign bus.readdata      = pipe[READ_LATENCY-1].data;
    assign bus.readdatavalid = pipe[READ_LATENCY-1].valid;

endmodule

// File: tb/tb_sysid_regs.sv
// Scoreboard bench for sysid_regs: one instance at read latency 1, one at 2.
module tb_sysid_regs;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset1;
    logic reset2;
    logic [127:0] user1 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    logic [127:0] user2 = '0;

    sysid_regs_if #(.ADDR_WIDTH(5)) bus1 ();
    sysid_regs_if #(.ADDR_WIDTH(5)) bus2 ();

    sysid_regs #(
        .ID_VALUE(32'h0000_0000), .TIMESTAMP(32'd1299134001), .NUM_USER(4),
        .ADDR_WIDTH(5), .READ_LATENCY(1), .VERSION(8'h02)
    ) dut1 (
        .clock(clock), .reset(reset1), .bus(bus1), .user_status(user1)
    );

    sysid_regs #(
        .ID_VALUE(32'hA5C3_0F12), .TIMESTAMP(32'd1299134001), .NUM_USER(4),
        .ADDR_WIDTH(5), .READ_LATENCY(2), .VERSION(8'h02)
    ) dut2 (
        .clock(clock), .reset(reset2), .bus(bus2), .user_status(user2)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [31:0] mask;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc    = 0;
    int   base2  = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per valid pulse, flag strays and overdue responses.
    always @(negedge clock) begin
        exp_t e;
        if (bus1.readdatavalid) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 stray valid: got readdata 0x%08h, want no response", bus1.readdata);
            end else begin
                e = q1.pop_front();
                check({"dut1 ", e.name}, bus1.readdata & e.mask, e.data & e.mask);
                check({"dut1 ", e.name, " cycle"}, 32'(cyc), 32'(e.due));
            end
        end else if (q1.size() > 0 && cyc > q1[0].due) begin
            e = q1.pop_front();
            checks++;
            errors++;
            $display("FAIL dut1 %s: got no readdatavalid, want one at cycle %0d", e.name, e.due);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus2.readdatavalid) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2 stray valid: got readdata 0x%08h, want no response", bus2.readdata);
            end else begin
                e = q2.pop_front();
                check({"dut2 ", e.name}, bus2.readdata & e.mask, e.data & e.mask);
                check({"dut2 ", e.name, " cycle"}, 32'(cyc), 32'(e.due));
            end
        end else if (q2.size() > 0 && cyc > q2[0].due) begin
            e = q2.pop_front();
            checks++;
            errors++;
            $display("FAIL dut2 %s: got no readdatavalid, want one at cycle %0d", e.name, e.due);
        end
    end

    task automatic drive1(input logic rd, input logic wr, input logic [4:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        @(negedge clock);
        bus1.read       = rd;
        bus1.write      = wr;
        bus1.address    = a;
        bus1.writedata  = wd;
        bus1.byteenable = be;
    endtask

    task automatic drive2(input logic rd, input logic wr, input logic [4:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        @(negedge clock);
        bus2.read       = rd;
        bus2.write      = wr;
        bus2.address    = a;
        bus2.writedata  = wd;
        bus2.byteenable = be;
    endtask

    task automatic rd1(input string name, input logic [4:0] a, input logic [31:0] exp,
                       input logic [31:0] mask = 32'hFFFF_FFFF);
        drive1(1'b1, 1'b0, a, 32'h0, 4'h0);
        q1.push_back('{name, exp, mask, cyc + 1});
    endtask

    // The uptime expectation is cycles since dut2 left reset, taken at the accept edge.
    task automatic rd2(input string name, input logic [4:0] a, input logic [31:0] exp,
                       input bit uptime = 1'b0);
        drive2(1'b1, 1'b0, a, 32'h0, 4'h0);
        q2.push_back('{name, uptime ? 32'(cyc - base2) : exp, 32'hFFFF_FFFF, cyc + 2});
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] wd, input logic [3:0] be);
        drive1(1'b0, 1'b1, a, wd, be);
    endtask

    task automatic idle1(input int n);
        repeat (n) drive1(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic idle2(input int n);
        repeat (n) drive2(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, want completion within 200us");
        $fatal(1, "timeout");
    end

    initial begin
        reset1 = 1'b1;
        reset2 = 1'b1;
        {bus1.read, bus1.write, bus1.address, bus1.writedata, bus1.byteenable} = '0;
        {bus2.read, bus2.write, bus2.address, bus2.writedata, bus2.byteenable} = '0;
        repeat (3) @(negedge clock);
        check("dut1 reset readdata", bus1.readdata, 32'h0);
        check("dut1 reset readdatavalid", 32'(bus1.readdatavalid), 32'h0);
        check("dut2 reset readdata", bus2.readdata, 32'h0);
        check("dut2 reset readdatavalid", 32'(bus2.readdatavalid), 32'h0);
        reset1 = 1'b0;
        reset2 = 1'b0;
        base2  = cyc;

        // Identity words and capability word.
        rd1("id", 5'd0, 32'h0000_0000);
        rd1("timestamp", 5'd1, 32'd1299134001);
        rd1("caps", 5'd5, 32'h0002_0401);

        // Scratch byte lanes; writes to read-only words are ignored.
        wr1(5'd4, 32'hDEAD_BEEF, 4'b1111);
        wr1(5'd4, 32'h0000_0011, 4'b0001);
        rd1("scratch byte lanes", 5'd4, 32'hDEAD_BE11);
        wr1(5'd0, 32'hFFFF_FFFF, 4'b1111);
        rd1("id after write", 5'd0, 32'h0000_0000);

        for (int k = 0; k < 4; k++) begin
            rd1($sformatf("user%0d", k), 5'(6 + k), user1[32*k +: 32]);
        end
        rd1("unmapped 10", 5'd10, 32'h0);
        rd1("unmapped 31", 5'd31, 32'h0);

        // Counter just below the 32-bit carry: lo snapshot, then high word carries.
        @(negedge clock);
        force dut1.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
        bus1.read    = 1'b1;
        bus1.address = 5'd2;
        q1.push_back('{"uptime lo at preload", 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc + 1});
        idle1(1);
        release dut1.u_uptime.count;
        idle1(9);
        rd1("shadow hi at preload", 5'd3, 32'h0000_0000);
        rd1("uptime lo after carry", 5'd2, 32'h0000_0000, 32'hFFFF_FF00);
        rd1("shadow hi after carry", 5'd3, 32'h0000_0001);

        // Clear ignores data/byteenable and leaves the shadow alone.
        wr1(5'd2, 32'h1234_5678, 4'b0000);
        rd1("shadow after clear", 5'd3, 32'h0000_0001);
        wr1(5'd2, 32'h0, 4'b1111);
        rd1("uptime right after clear", 5'd2, 32'h0000_0000);
        idle1(2);
        rd1("uptime three after clear", 5'd2, 32'h0000_0003);
        rd1("shadow after post-clear read", 5'd3, 32'h0000_0000);

        // Read and write together: write lands, no response.
        drive1(1'b1, 1'b1, 5'd4, 32'hCAFE_F00D, 4'b1111);
        rd1("scratch after read+write", 5'd4, 32'hCAFE_F00D);
        idle1(3);

        // Latency-2 instance: full-rate reads across the whole map.
        rd2("id", 5'd0, 32'hA5C3_0F12);
        rd2("timestamp", 5'd1, 32'd1299134001);
        rd2("uptime lo", 5'd2, 32'h0, 1'b1);
        rd2("shadow hi", 5'd3, 32'h0);
        rd2("scratch", 5'd4, 32'h0);
        rd2("caps", 5'd5, 32'h0002_0402);
        for (int k = 0; k < 4; k++) begin
            rd2($sformatf("user%0d", k), 5'(6 + k), 32'h0);
        end
        rd2("unmapped 10", 5'd10, 32'h0);
        rd2("unmapped 31", 5'd31, 32'h0);
        idle2(1);

        // Reset with reads still in the pipe: they must never appear.
        wr2_scratch();
        rd2("pre-reset id", 5'd0, 32'hA5C3_0F12);
        rd2("pre-reset timestamp", 5'd1, 32'd1299134001);
        rd2("pre-reset caps", 5'd5, 32'h0002_0402);
        @(negedge clock);
        #1;
        bus2.read = 1'b0;
        reset2    = 1'b1;
        q2.delete();
        repeat (2) @(negedge clock);
        check("dut2 mid-reset readdata", bus2.readdata, 32'h0);
        check("dut2 mid-reset readdatavalid", 32'(bus2.readdatavalid), 32'h0);
        reset2 = 1'b0;
        base2  = cyc;
        idle2(4);
        rd2("scratch after reset", 5'd4, 32'h0);
        rd2("uptime after reset", 5'd2, 32'h0, 1'b1);
        idle2(5);

        check("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
        check("dut2 scoreboard drained", 32'(q2.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic wr2_scratch();
        drive2(1'b0, 1'b1, 5'd4, 32'h5555_AAAA, 4'b1111);
    endtask

endmodule
